// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - streaming 3x3 neighbourhood generator feeding sobel_module.
// Optional window-centre coordinate outputs are enabled with SOBEL_WIN_COORD_EN.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PIX_W-1:0]              pix_in,
  input  logic                          pix_valid,
  input  logic                          frame_start,
  output logic [PIX_W-1:0]              p0,
  output logic [PIX_W-1:0]              p1,
  output logic [PIX_W-1:0]              p2,
  output logic [PIX_W-1:0]              p3,
  output logic [PIX_W-1:0]              p5,
  output logic [PIX_W-1:0]              p6,
  output logic [PIX_W-1:0]              p7,
  output logic [PIX_W-1:0]              p8,
  output logic                          win_valid,
`ifdef SOBEL_WIN_COORD_EN
  output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_y,
`endif
  output logic                          frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] r_lb2 [IMG_WIDTH];
  logic [PIX_W-1:0] r_top [3];
  logic [PIX_W-1:0] r_mid [3];
  logic [PIX_W-1:0] r_bot [3];
  logic             r_win_valid;
  logic             r_frame_done;

  logic [CW-1:0]    w_x;
  logic [RW-1:0]    w_y;
  logic [PIX_W-1:0] w_lb1_rd;
  logic [PIX_W-1:0] w_lb2_rd;
  logic             w_is_win;
  logic             w_is_last;

  // frame_start forces the current pixel to (0,0) whatever the counters say
  assign w_x       = frame_start ? '0 : r_col;
  assign w_y       = frame_start ? '0 : r_row;
  assign w_lb1_rd  = r_lb1[w_x];
  assign w_lb2_rd  = r_lb2[w_x];
  assign w_is_win  = (w_x >= CW'(2)) && (w_y >= RW'(2));
  assign w_is_last = (w_x == COL_LAST) && (w_y == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pix_valid) begin
      if (w_x == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_y == ROW_LAST) ? '0 : w_y + RW'(1);
      end else begin
        r_col <= w_x + CW'(1);
        r_row <= w_y;
      end
    end
  end

  // Line buffers are plain RAM: no reset, stale rows are masked by w_is_win
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      r_lb2[w_x] <= w_lb1_rd;
      r_lb1[w_x] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top        <= '{default: '0};
      r_mid        <= '{default: '0};
      r_bot        <= '{default: '0};
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_win_valid  <= pix_valid && w_is_win;
      r_frame_done <= pix_valid && w_is_last;
      if (pix_valid) begin
        r_top <= '{r_top[1], r_top[2], w_lb2_rd};
        r_mid <= '{r_mid[1], r_mid[2], w_lb1_rd};
        r_bot <= '{r_bot[1], r_bot[2], pix_in};
      end
    end
  end

`ifdef SOBEL_WIN_COORD_EN
  logic [CW-1:0] r_win_x;
  logic [RW-1:0] r_win_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_x <= '0;
      r_win_y <= '0;
    end else if (pix_valid && w_is_win) begin
      r_win_x <= w_x - CW'(1);
      r_win_y <= w_y - RW'(1);
    end
  end

  assign win_x = r_win_x;
  assign win_y = r_win_y;
`endif

  // index 2 is the newest column (x), index 0 the oldest (x-2)
  assign p0         = r_top[0];
  assign p1         = r_top[1];
  assign p2         = r_top[2];
  assign p3         = r_mid[0];
  assign p5         = r_mid[2];
  assign p6         = r_bot[0];
  assign p7         = r_bot[1];
  assign p8         = r_bot[2];
  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - self-checking bench for sobel_window_gen against an image-array model.
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       frame_start;
  logic [7:0] p0, p1, p2, p3, p5, p6, p7, p8;
  logic       win_valid;
  logic       frame_done;
`ifdef SOBEL_WIN_COORD_EN
  logic [1:0] win_x;
  logic [1:0] win_y;
`endif

  always #5 clk = ~clk;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .p0          (p0),
    .p1          (p1),
    .p2          (p2),
    .p3          (p3),
    .p5          (p5),
    .p6          (p6),
    .p7          (p7),
    .p8          (p8),
    .win_valid   (win_valid),
`ifdef SOBEL_WIN_COORD_EN
    .win_x       (win_x),
    .win_y       (win_y),
`endif
    .frame_done  (frame_done)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         n_pulse = 0;
  logic [7:0] img [H][W];
  logic [7:0] ew [9];
  int         mx, my, ecx, ecy;
  logic       ewv, efd, hold_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; ecx = 0; ecy = 0;
    ewv = 1'b0; efd = 1'b0; hold_ok = 1'b1;
    for (int i = 0; i < 9; i++) ew[i] = 8'h00;
  endtask

  task automatic check_outputs();
    logic [7:0] obs [9];
    obs = '{p0, p1, p2, p3, 8'h00, p5, p6, p7, p8};
    check("win_valid", {31'd0, win_valid}, {31'd0, ewv});
    check("frame_done", {31'd0, frame_done}, {31'd0, efd});
    if (hold_ok) begin
      for (int i = 0; i < 9; i++)
        if (i != 4) check($sformatf("p%0d", i), {24'd0, obs[i]}, {24'd0, ew[i]});
    end
`ifdef SOBEL_WIN_COORD_EN
    check("win_x", {30'd0, win_x}, ecx);
    check("win_y", {30'd0, win_y}, ecy);
`endif
  endtask

  task automatic push(input logic v, input logic fs, input logic [7:0] px);
    pix_valid = v; frame_start = fs; pix_in = px;
    @(posedge clk);
    if (v) begin
      if (fs) begin mx = 0; my = 0; end
      img[my][mx] = px;
      ewv = (mx >= 2) && (my >= 2);
      efd = (mx == W - 1) && (my == H - 1);
      if (ewv) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            ew[r*3+c] = img[my-2+r][mx-2+c];
        ecx = mx - 1; ecy = my - 1;
      end
      hold_ok = ewv;
      mx++;
      if (mx == W) begin
        mx = 0;
        my = (my == H - 1) ? 0 : my + 1;
      end
    end else begin
      ewv = 1'b0; efd = 1'b0;
    end
    #1;
    if (win_valid === 1'b1) n_pulse++;
    check_outputs();
  endtask

  task automatic frame(input int base, input bit fs, input int gap, input bit rnd);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        push(1'b1, fs && x == 0 && y == 0, rnd ? 8'($urandom) : 8'(base + 16*y + x));
        for (int g = 0; g < gap; g++) push(1'b0, 1'($urandom), 8'($urandom));
      end
  endtask

  initial begin
    rst_n = 1'b0; pix_valid = 1'b0; frame_start = 1'b0; pix_in = 8'h00;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // continuous frame of 16*y+x
    n_pulse = 0;
    frame(0, 1'b1, 0, 1'b0);
    check("pulses_cont", n_pulse, 2);
    check("held_p0", {24'd0, p0}, 32'h01);
    check("held_p3", {24'd0, p3}, 32'h11);
    check("held_p8", {24'd0, p8}, 32'h23);

    // same frame with 3 idle cycles between pixels
    n_pulse = 0;
    frame(0, 1'b1, 3, 1'b0);
    check("pulses_gap", n_pulse, 2);

    // back-to-back frames, second offset by 0x80
    n_pulse = 0;
    frame(0, 1'b1, 0, 1'b0);
    frame(8'h80, 1'b0, 0, 1'b0);
    check("pulses_b2b", n_pulse, 4);
    check("b2b_p0", {24'd0, p0}, 32'h81);
    check("b2b_p8", {24'd0, p8}, 32'hA3);

    // restart mid-row 1, then a full random frame
    n_pulse = 0;
    for (int i = 0; i < W + 2; i++) push(1'b1, i == 0, 8'($urandom));
    check("pulses_partial", n_pulse, 0);
    frame(0, 1'b1, 0, 1'b1);
    check("pulses_restart", n_pulse, 2);

    // asynchronous reset mid-row 2, then a frame without frame_start
    for (int i = 0; i < 2*W + 3; i++) push(1'b1, i == 0, 8'($urandom));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_pulse = 0;
    frame(0, 1'b0, 1, 1'b1);
    check("pulses_post_rst", n_pulse, 2);

    // random frames with random idle gaps
    for (int f = 0; f < 4; f++) begin
      n_pulse = 0;
      frame(0, f[0], $urandom_range(0, 2), 1'b1);
      check("pulses_rand", n_pulse, 2);
    end
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Streaming 3x3 neighbourhood generator that feeds sobel_module.
- Accepts a raster-order pixel stream, one pixel per cycle with qualifier.
- Buffers two previous image lines and emits the eight neighbour pixels p0..p8 (centre p4 excluded) plus a window-valid strobe.
- Sits between the pixel source (camera/frame reader) and sobel_module; outputs drive sobel_module p-inputs directly.

Parameters:
IMG_WIDTH, 640, active pixels per line (>=3)
IMG_HEIGHT, 480, lines per frame (>=3)
PIX_W, 8, pixel bit width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pix_in  in  PIX_W  incoming pixel, raster order
pix_valid  in  1  pix_in qualifier; one pixel accepted per cycle when high
frame_start  in  1  sampled only with pix_valid; marks pix_in as pixel (0,0)
p0,p1,p2  out  PIX_W each  window top row, left to right
p3,p5  out  PIX_W each  window middle row left, right
p6,p7,p8  out  PIX_W each  window bottom row, left to right
win_valid  out  1  p0..p8 hold a complete window this cycle
frame_done  out  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Reset (async on rst_n low): col/row counters = 0; p0..p8 = 0; win_valid = 0; frame_done = 0; shift registers = 0. Line-buffer RAM contents are not cleared and need not be.
- Counters: col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1. Advance only on accepted pixel (pix_valid=1). col wraps to 0 and row increments at end of line. At (W-1,H-1), both wrap to 0.
- frame_start=1 with pix_valid=1: current pixel is (0,0) regardless of counter state. Next pixel is (1,0). Valid at any point, including mid-frame restart.
- Two line buffers, depth IMG_WIDTH, PIX_W wide:
  - lb1 holds row y-1.
  - lb2 holds row y-2.
  - Read and write happen at address col on each accepted pixel: lb2[col] <= lb1[col], lb1[col] <= pix_in.
- Three 3-deep column shift registers (rows y-2, y-1, y) shift on each accepted pixel.
- Window mapping for accepted pixel at (x,y):
  - p8=(x,y), p7=(x-1,y), p6=(x-2,y)
  - p5=(x,y-1), p3=(x-2,y-1)
  - p2=(x,y-2), p1=(x-1,y-2), p0=(x-2,y-2)
  - Window centre is (x-1,y-1).
- Latency: outputs registered. p0..p8 and win_valid update on the clock edge after the edge accepting pixel (x,y), i.e. 1 cycle.
- win_valid=1 for exactly one cycle per accepted pixel with x>=2 and y>=2. Otherwise 0. Gives (W-2)*(H-2) windows per frame; no border windows, no padding.
- Rows do not wrap: windows never straddle line ends. With x<2 the shift contents are stale, and win_valid is suppressed.
- pix_valid=0: counters, buffers, shift registers and p0..p8 hold; win_valid=0.
- frame_done: 1-cycle pulse, same timing as the win_valid for pixel (W-1,H-1).
- Mid-frame frame_start: previous rows in the buffers are stale. Windows still suppressed until new row>=2, so no stale data escapes.
- Reset mid-frame: stream restarts at (0,0) on the next accepted pixel. frame_start is not required.

Optional Feature:
SOBEL_WIN_COORD_EN
- Defined: adds outputs win_x [$clog2(IMG_WIDTH)-1:0] and win_y [$clog2(IMG_HEIGHT)-1:0].
  - Coordinates of the window centre (x-1,y-1), registered alongside p0..p8.
  - Reset 0; hold when win_valid=0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Parameters W=4, H=3 for all cases below. Feed pixels 16*y+x continuously with frame_start on the first.
  - Exactly 2 win_valid pulses.
  - First pulse: p0=00 p1=01 p2=02 p3=10 p5=12 p6=20 p7=21 p8=22.
  - Second pulse: p0=01 p1=02 p2=03 p3=11 p5=13 p6=21 p7=22 p8=23; frame_done high on this same cycle.
  - With SOBEL_WIN_COORD_EN: win_x/win_y = 1/1, then 2/1.
- Same stream with pix_valid deasserted 3 cycles between every pixel:
  - Identical window values.
  - win_valid only the cycle after an accepted pixel.
  - Outputs held during gaps.
- Two back-to-back frames, second with values +0x80: second frame's first window p0=80 ... p8=A2, with no extra or missing pulses.
- Assert frame_start mid-row 1 of a frame, then a full frame:
  - No win_valid until new row 2.
  - Windows match the new frame only.
- Pulse rst_n low for 1 cycle mid-row 2:
  - All outputs 0 immediately (asynchronous).
  - A subsequent full frame without frame_start yields correct windows.
- Check rst_n low at time 0: p0..p8=0, win_valid=0, frame_done=0 before the first clock edge.
